// File: rtl/platform_clk_div_gen.sv
// Runtime-programmable clock-enable generator: NUM_CLKS divided channels in the refclk domain.
// Define CLKGEN_GATE_EN to add the per-channel clk_gate_i output gating input.
module platform_clk_div_gen #(
  parameter int unsigned NUM_CLKS    = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk_i,
  input  logic                rst_i,
  input  logic                cfg_wr_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic [DIV_W-1:0]    cfg_phase_i,
`ifdef CLKGEN_GATE_EN
  input  logic [NUM_CLKS-1:0] clk_gate_i,
`endif
  output logic                cfg_err_o,
  output logic [NUM_CLKS-1:0] clk_en_o,
  output logic [NUM_CLKS-1:0] clk_out_o,
  output logic                locked_o
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES);

  typedef enum logic [0:0] {StSettle, StLocked} state_e;

  state_e               state_q, state_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                 locked_q, locked_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0]     div_q   [NUM_CLKS];
  logic [DIV_W-1:0]     div_d   [NUM_CLKS];
  logic [DIV_W-1:0]     phase_q [NUM_CLKS];
  logic [DIV_W-1:0]     phase_d [NUM_CLKS];
  logic [DIV_W-1:0]     cnt_q   [NUM_CLKS];
  logic [DIV_W-1:0]     cnt_d   [NUM_CLKS];
  logic [DIV_W:0]       h_w     [NUM_CLKS];
  logic [NUM_CLKS-1:0]  bypass_w;
  logic [NUM_CLKS-1:0]  clk_en_q, clk_en_d;
  logic [NUM_CLKS-1:0]  clk_out_q, clk_out_d;
  logic [NUM_CLKS-1:0]  gate;
  logic                 ch_ok, phase_ok, accept;

`ifdef CLKGEN_GATE_EN
  assign gate = clk_gate_i;
`else
  assign gate = '0;
`endif

  assign ch_ok     = {{(32-CH_W){1'b0}}, cfg_ch_i} < NUM_CLKS;
  assign phase_ok  = (cfg_div_i < DIV_W'(2)) || (cfg_phase_i < cfg_div_i);
  assign accept    = cfg_wr_i & ch_ok & phase_ok;
  assign cfg_err_d = cfg_wr_i & ~(ch_ok & phase_ok);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StSettle: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          state_d = StLocked;
        end
      end
      StLocked: state_d = StLocked;
    endcase
    // A write landing on the lock edge still wins and restarts settling.
    if (accept) begin
      state_d    = StSettle;
      lock_cnt_d = '0;
    end
  end

  assign locked_d = (state_d == StLocked);

  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      div_d[i]    = div_q[i];
      phase_d[i]  = phase_q[i];
      bypass_w[i] = div_q[i] < DIV_W'(2);
      // Position within the period relative to phase; one spare bit so div near 2^DIV_W is safe.
      h_w[i] = {1'b0, cnt_q[i]} + {1'b0, div_q[i]} - {1'b0, phase_q[i]};
      if (h_w[i] >= {1'b0, div_q[i]}) begin
        h_w[i] = h_w[i] - {1'b0, div_q[i]};
      end

      if (bypass_w[i] || (cnt_q[i] == div_q[i] - 1'b1)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (accept) begin
        cnt_d[i] = '0;
        if (CH_W'(i) == cfg_ch_i) begin
          div_d[i]   = cfg_div_i;
          phase_d[i] = cfg_phase_i;
        end
      end

      clk_en_d[i]  = locked_d & ~gate[i] & (bypass_w[i] | (cnt_q[i] == phase_q[i]));
      clk_out_d[i] = locked_d & ~gate[i] & ~bypass_w[i] &
                     (h_w[i] < {2'b00, div_q[i][DIV_W-1:1]});
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      clk_en_q   <= '0;
      clk_out_q  <= '0;
      for (int i = 0; i < NUM_CLKS; i++) begin
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
      clk_en_q   <= clk_en_d;
      clk_out_q  <= clk_out_d;
      for (int i = 0; i < NUM_CLKS; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign cfg_err_o = cfg_err_q;
  assign clk_en_o  = clk_en_q;
  assign clk_out_o = clk_out_q;
  assign locked_o  = locked_q;

endmodule

// File: tb/tb_platform_clk_div_gen.sv
// Self-checking bench for platform_clk_div_gen: directed vectors plus random traffic vs a
// time-since-alignment reference model. Gating checks compile in when CLKGEN_GATE_EN is defined.
module tb_platform_clk_div_gen;

  localparam int unsigned NUM_CLKS    = 3;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int unsigned DEFAULT_DIV = 2;
  localparam int unsigned CH_W        = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;

  typedef struct {
    int ch;
    int div;
    int phase;
    bit exp_err;
  } wr_vec_t;

  logic                refclk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_wr = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [DIV_W-1:0]    cfg_div = '0;
  logic [DIV_W-1:0]    cfg_phase = '0;
  logic [NUM_CLKS-1:0] clk_gate = '0;
  logic                cfg_err;
  logic [NUM_CLKS-1:0] clk_en;
  logic [NUM_CLKS-1:0] clk_out;
  logic                locked;

  always #5 refclk = ~refclk;

  platform_clk_div_gen #(
    .NUM_CLKS   (NUM_CLKS),
    .DIV_W      (DIV_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .refclk_i   (refclk),
    .rst_i      (rst),
    .cfg_wr_i   (cfg_wr),
    .cfg_ch_i   (cfg_ch),
    .cfg_div_i  (cfg_div),
    .cfg_phase_i(cfg_phase),
`ifdef CLKGEN_GATE_EN
    .clk_gate_i (clk_gate),
`endif
    .cfg_err_o  (cfg_err),
    .clk_en_o   (clk_en),
    .clk_out_o  (clk_out),
    .locked_o   (locked)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint t0 = 0;      // first cycle of the current settle window; channel counters are 0 here
  int     mdiv   [NUM_CLKS];
  int     mphase [NUM_CLKS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    logic                s_rst, s_wr;
    int                  s_ch, s_div, s_ph;
    logic [NUM_CLKS-1:0] s_gate;
    logic [NUM_CLKS-1:0] e_en, e_out;
    logic                e_lock, e_err;
    bit                  valid, acc;
    longint              cn, h;
    s_rst = rst;
    s_wr  = cfg_wr;
    s_ch  = int'(cfg_ch);
    s_div = int'(cfg_div);
    s_ph  = int'(cfg_phase);
`ifdef CLKGEN_GATE_EN
    s_gate = clk_gate;
`else
    s_gate = '0;
`endif
    @(posedge refclk);
    #1;
    cyc++;
    e_en  = '0;
    e_out = '0;
    e_lock = 1'b0;
    e_err  = 1'b0;
    if (s_rst) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        mdiv[i]   = DEFAULT_DIV;
        mphase[i] = 0;
      end
      t0 = cyc;
    end else begin
      valid  = (s_ch < NUM_CLKS) && !(s_div >= 2 && s_ph >= s_div);
      acc    = s_wr && valid;
      e_err  = s_wr && !valid;
      e_lock = !acc && ((cyc - t0) >= LOCK_CYCLES);
      if (e_lock) begin
        for (int i = 0; i < NUM_CLKS; i++) begin
          if (!s_gate[i]) begin
            if (mdiv[i] < 2) begin
              e_en[i] = 1'b1;
            end else begin
              cn       = (cyc - 1 - t0) % mdiv[i];
              h        = (cn - mphase[i] + mdiv[i]) % mdiv[i];
              e_en[i]  = (cn == mphase[i]);
              e_out[i] = (h < mdiv[i] / 2);
            end
          end
        end
      end
      if (acc) begin
        mdiv[s_ch]   = s_div;
        mphase[s_ch] = s_ph;
        t0           = cyc;
      end
    end
    chk("model_locked", locked, e_lock);
    chk("model_cfg_err", cfg_err, e_err);
    chk("model_clk_en", clk_en, e_en);
    chk("model_clk_out", clk_out, e_out);
  endtask

  task automatic do_write(input int ch, input int div, input int ph);
    cfg_wr    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(div);
    cfg_phase = DIV_W'(ph);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 4 * LOCK_CYCLES) begin
      step();
      n++;
    end
    if (locked !== 1'b1) timeout("wait_locked");
  endtask

  wr_vec_t vecs [6];
  int      n, f, s, ones;
  logic [31:0] en_hist, out_hist;
  longint  last_en;
  logic    prev_en;

  initial begin
    vecs[0] = '{ch: 0, div: 4, phase: 4, exp_err: 1'b1};
    vecs[1] = '{ch: 3, div: 3, phase: 0, exp_err: 1'b1};
    vecs[2] = '{ch: 1, div: 5, phase: 5, exp_err: 1'b1};
    vecs[3] = '{ch: 2, div: 5, phase: 4, exp_err: 1'b0};
    vecs[4] = '{ch: 0, div: 1, phase: 9, exp_err: 1'b0};
    vecs[5] = '{ch: 2, div: 0, phase: 3, exp_err: 1'b0};

    // Reset and default lock timing
    rst = 1'b1;
    step();
    step();
    chk("rst_clk_en", clk_en, '0);
    chk("rst_clk_out", clk_out, '0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= LOCK_CYCLES + 4; k++) begin
      step();
      if (k == LOCK_CYCLES - 1) chk("locked_cycle15", locked, 1'b0);
      if (k == LOCK_CYCLES)     chk("locked_cycle16", locked, 1'b1);
      if (k == LOCK_CYCLES + 1) begin
        chk("ch0_en_first", clk_en[0], 1'b1);
        chk("ch0_out_first", clk_out[0], 1'b1);
      end
      if (k == LOCK_CYCLES + 2) begin
        chk("ch0_en_second", clk_en[0], 1'b0);
        chk("ch0_out_second", clk_out[0], 1'b0);
      end
    end

    // ch1 div=5 phase=2 while locked
    do_write(1, 5, 2);
    chk("wr1_cfg_err", cfg_err, 1'b0);
    chk("wr1_unlock", locked, 1'b0);
    wait_locked(n);
    chk("wr1_relock_cycles", n, LOCK_CYCLES);
    for (int k = 0; k < 20; k++) begin
      step();
      en_hist[k]  = clk_en[1];
      out_hist[k] = clk_out[1];
    end
    f = -1;
    s = -1;
    for (int k = 0; k < 20; k++) begin
      if (en_hist[k] && f < 0) f = k;
      else if (en_hist[k] && f >= 0 && s < 0) s = k;
    end
    if (f < 1 || s < 0 || f + 4 >= 20) begin
      timeout("ch1_pulse_search");
    end else begin
      chk("ch1_period", s - f, 5);
      chk("ch1_rise_with_en", {out_hist[f - 1], out_hist[f]}, 2'b01);
      ones = 0;
      for (int k = f; k < f + 5; k++) ones += int'(out_hist[k]);
      chk("ch1_high_cycles", ones, 2);
    end

    // Table of writes: rejects keep lock, accepts drop it
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].ch, vecs[i].div, vecs[i].phase);
      chk("vec_cfg_err", cfg_err, vecs[i].exp_err);
      chk("vec_locked", locked, vecs[i].exp_err);
      wait_locked(n);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bypass_ch0_en", clk_en[0], 1'b1);
      chk("bypass_ch0_out", clk_out[0], 1'b0);
    end

    // Writes on settle cycles 10 and 15, then reset mid-settle
    do_write(1, 3, 1);
    for (int k = 0; k < 10; k++) step();
    do_write(1, 4, 3);
    for (int k = 0; k < 15; k++) step();
    do_write(2, 6, 5);
    chk("wr_on_lock_edge", locked, 1'b0);
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    cfg_wr = 1'b1;
    cfg_ch = CH_W'(0);
    cfg_div = DIV_W'(7);
    cfg_phase = '0;
    step();
    rst = 1'b0;
    cfg_wr = 1'b0;
    chk("post_rst_outputs", {cfg_err, locked, clk_en, clk_out}, '0);
    wait_locked(n);
    chk("post_rst_relock", n, LOCK_CYCLES);
    prev_en = clk_en[1];
    step();
    chk("post_rst_div2_toggle", clk_en[1] ^ prev_en, 1'b1);

    // Largest divide ratio; crosses the half-period point of a 2^16-1 period
    do_write(2, 65535, 0);
    wait_locked(n);
    for (int k = 0; k < 32790; k++) step();

`ifdef CLKGEN_GATE_EN
    // Gate ch0 for 13 cycles; first pulse after release stays on the 8-cycle grid
    do_write(0, 8, 0);
    wait_locked(n);
    n = 0;
    while (clk_en[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (clk_en[0] !== 1'b1) timeout("gate_first_pulse");
    last_en = cyc;
    clk_gate = 3'b001;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("gated_outputs", {clk_en[0], clk_out[0]}, 2'b00);
    end
    clk_gate = '0;
    n = 0;
    do begin
      step();
      n++;
    end while (clk_en[0] !== 1'b1 && n < 20);
    if (clk_en[0] !== 1'b1) timeout("ungate_pulse");
    else chk("ungate_grid", (cyc - last_en) % 8, 0);
    chk("gate_keeps_lock", locked, 1'b1);
`endif

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 399) == 0);
      cfg_wr    = ($urandom_range(0, 29) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = DIV_W'($urandom_range(0, 12));
      cfg_phase = DIV_W'($urandom_range(0, 12));
`ifdef CLKGEN_GATE_EN
      if ($urandom_range(0, 19) == 0) clk_gate = NUM_CLKS'($urandom);
`endif
      step();
    end
    rst = 1'b0;
    cfg_wr = 1'b0;
    clk_gate = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
